// File: rtl/uart_tx_multi.sv
// rtl/uart_tx_multi.sv - FIFO-fed UART transmitter with per-frame data length, parity and stop config
//
// Parameters: DATA_WD (5..9), OVERSAMPLING_RATE (ticks per bit), FIFO_DEPTH (power of two),
//             CNT_WD (fifo_count width)
// Inputs:  clk, rst_n (async active-low), tick (oversampling strobe), wr_en/din (FIFO push),
//          data_len, parity_mode (1 odd, 2 even, else none), stop2
// Outputs: tx (idles high), tx_busy, tx_done (end-of-frame pulse), full, empty, fifo_count,
//          overflow (dropped-write pulse)
// Optional: define UART_TX_BREAK_EN to add input send_break, which in IDLE takes priority over
//           the FIFO and holds tx low for 2*(1+DATA_WD+2) bit periods, then one stop bit.
module uart_tx_multi #(
    parameter int DATA_WD           = 8,
    parameter int OVERSAMPLING_RATE = 16,
    parameter int FIFO_DEPTH        = 8,
    parameter int CNT_WD            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               wr_en,
    input  logic [DATA_WD-1:0] din,
    input  logic [3:0]         data_len,
    input  logic [1:0]         parity_mode,
    input  logic               stop2,
`ifdef UART_TX_BREAK_EN
    input  logic               send_break,
`endif
    output logic               tx,
    output logic               tx_busy,
    output logic               tx_done,
    output logic               full,
    output logic               empty,
    output logic [CNT_WD-1:0]  fifo_count,
    output logic               overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(OVERSAMPLING_RATE);
`ifdef UART_TX_BREAK_EN
    localparam int BREAK_BITS = 2 * (1 + DATA_WD + 2);
`endif

    typedef enum logic [6:0] {
        IDLE   = 7'b0000001,
        START  = 7'b0000010,
        DATA   = 7'b0000100,
        PARITY = 7'b0001000,
        STOP   = 7'b0010000,
        DONE   = 7'b0100000,
        BRK    = 7'b1000000
    } state_t;

    state_t             state;
    logic [DATA_WD-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               wr_ok;
    logic               pop;
    logic               start_break;

    logic [DATA_WD-1:0] head;
    logic [DATA_WD-1:0] head_masked;
    logic [3:0]         len_in;
    logic               par_in;
    logic               par_en_in;

    logic [TW-1:0]      tick_count;
    logic [4:0]         bit_index;
    logic               bit_end;
    logic [DATA_WD-1:0] shreg;
    logic [3:0]         len_q;
    logic               par_en_q;
    logic               par_q;
    logic               stop2_q;

    assign full  = (fifo_count == CNT_WD'(FIFO_DEPTH));
    assign empty = (fifo_count == '0);
    assign wr_ok = wr_en && !full;

`ifdef UART_TX_BREAK_EN
    assign start_break = (state == IDLE) && send_break;
`else
    assign start_break = 1'b0;
`endif
    assign pop = (state == IDLE) && !empty && !start_break;

    // Frame config is decoded from the live inputs and captured only at pop time.
    assign head      = mem[rd_ptr];
    assign len_in    = (data_len < 4'd5 || int'(data_len) > DATA_WD) ? 4'(DATA_WD) : data_len;
    assign par_en_in = (parity_mode == 2'd1) || (parity_mode == 2'd2);

    // Bits above the frame length are zeroed so they neither transmit nor enter the parity.
    always_comb begin
        head_masked = '0;
        for (int i = 0; i < DATA_WD; i++) begin
            if (i < int'(len_in)) head_masked[i] = head[i];
        end
    end
    assign par_in = (parity_mode == 2'd1) ? ~^head_masked : ^head_masked;

    assign bit_end = tick && (tick_count == TW'(OVERSAMPLING_RATE - 1));

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= wr_en && full;
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tick_count <= '0;
            bit_index  <= '0;
            shreg      <= '0;
            len_q      <= '0;
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
            stop2_q    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (tick) tick_count <= bit_end ? '0 : tick_count + 1'b1;

            case (state)
                IDLE: begin
                    tx         <= 1'b1;
                    tx_busy    <= 1'b0;
                    tick_count <= '0;
                    bit_index  <= '0;
                    if (start_break) begin
                        state   <= BRK;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                    end else if (pop) begin
                        shreg    <= head_masked;
                        len_q    <= len_in;
                        par_en_q <= par_en_in;
                        par_q    <= par_in;
                        stop2_q  <= stop2;
                        state    <= START;
                        tx       <= 1'b0;
                        tx_busy  <= 1'b1;
                    end
                end
                START: if (bit_end) begin
                    state <= DATA;
                    tx    <= shreg[0];
                end
                DATA: if (bit_end) begin
                    if (bit_index == 5'(len_q - 4'd1)) begin
                        bit_index <= '0;
                        if (par_en_q) begin
                            state <= PARITY;
                            tx    <= par_q;
                        end else begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end
                    end else begin
                        bit_index <= bit_index + 1'b1;
                        shreg     <= shreg >> 1;
                        tx        <= shreg[1];
                    end
                end
                PARITY: if (bit_end) begin
                    state     <= STOP;
                    tx        <= 1'b1;
                    bit_index <= '0;
                end
                // bit_index counts the stop bits already sent.
                STOP: if (bit_end) begin
                    if (stop2_q && bit_index == '0) begin
                        bit_index <= 5'd1;
                    end else begin
                        state   <= DONE;
                        tx_done <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
`ifdef UART_TX_BREAK_EN
                // bit_index counts whole bit periods of the break.
                BRK: if (bit_end) begin
                    if (bit_index == 5'(BREAK_BITS - 1)) begin
                        state     <= STOP;
                        tx        <= 1'b1;
                        bit_index <= '0;
                        stop2_q   <= 1'b0;
                    end else begin
                        bit_index <= bit_index + 1'b1;
                    end
                end
`endif
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_multi.sv
// tb/tb_uart_tx_multi.sv - scoreboard bench for uart_tx_multi with a frame-level reference model
`timescale 1ns/1ps
module tb_uart_tx_multi;

    localparam int DW  = 8;
    localparam int OSR = 16;
    localparam int FD  = 8;
    localparam int CW  = $clog2(FD) + 1;

    typedef struct {
        logic [31:0] bits;
        int          n;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic [3:0]    data_len = 4'd8;
    logic [1:0]    parity_mode = 2'd0;
    logic          stop2 = 1'b0;
`ifdef UART_TX_BREAK_EN
    logic          send_break = 1'b0;
`endif
    logic          tx, tx_busy, tx_done, full, empty, overflow;
    logic [CW-1:0] fifo_count;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_pushed = 0;
    int   done_cnt = 0;
    int   ovf_cnt = 0;
    int   mon_n = 0;
    logic in_frame = 1'b0;

    uart_tx_multi #(.DATA_WD(DW), .OVERSAMPLING_RATE(OSR), .FIFO_DEPTH(FD), .CNT_WD(CW)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .wr_en(wr_en), .din(din),
        .data_len(data_len), .parity_mode(parity_mode), .stop2(stop2),
`ifdef UART_TX_BREAK_EN
        .send_break(send_break),
`endif
        .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done), .full(full), .empty(empty),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #2;
            ph++;
            tick = (ph % 2 == 0);
        end
    end

    always @(negedge clk) begin
        if (tx_done)  done_cnt++;
        if (overflow) ovf_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame as a list of line levels, one per bit period, LSB of bits first on the wire.
    function automatic exp_t model(input logic [7:0] d, input logic [3:0] dl,
                                   input logic [1:0] pm, input logic s2);
        exp_t e;
        int len, ones, k;
        len  = (dl < 5 || dl > DW) ? DW : int'(dl);
        ones = 0;
        e.bits = '0;
        for (int i = 0; i < len; i++) begin
            e.bits[1+i] = d[i];
            ones += int'(d[i]);
        end
        k = 1 + len;
        if (pm == 2'd1) begin
            e.bits[k] = (ones % 2 == 0);
            k++;
        end else if (pm == 2'd2) begin
            e.bits[k] = (ones % 2 == 1);
            k++;
        end
        e.bits[k] = 1'b1;
        k++;
        if (s2) begin
            e.bits[k] = 1'b1;
            k++;
        end
        e.n = k;
        return e;
    endfunction

    // Monitor: on a falling line, capture each bit at the middle tick of its period.
    initial begin
        exp_t        e;
        logic [31:0] got;
        logic        aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0 && !in_frame) begin
                check("start_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    in_frame = 1'b1;
                    got = '0;
                    mon_n = 0;
                    aborted = 1'b0;
                    while (1) begin
                        if (!rst_n) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (tick) begin
                            if (mon_n % OSR == OSR / 2) got[mon_n / OSR] = tx;
                            mon_n++;
                        end
                        if (mon_n >= e.n * OSR) break;
                        @(negedge clk);
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        check("tx_done_at_frame_end", 32'(tx_done), 32'd1);
                        check("tx_high_in_done", 32'(tx), 32'd1);
                        check("frame_bits", got, e.bits);
                        @(negedge clk);
                        check("tx_done_one_cycle", 32'(tx_done), 32'd0);
                    end
                    in_frame = 1'b0;
                    mon_n = 0;
                end
            end
        end
    end

    task automatic set_cfg(input int dl, input int pm, input int s2);
        @(posedge clk);
        #1;
        data_len    = 4'(dl);
        parity_mode = 2'(pm);
        stop2       = 1'(s2);
    endtask

    task automatic push_write(input logic [7:0] d);
        @(posedge clk);
        #1;
        wr_en = 1'b1;
        din   = d;
        sb.push_back(model(d, data_len, parity_mode, stop2));
        n_pushed++;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_busy();
        int c;
        c = 0;
        while (c < 1000 && tx_busy !== 1'b1) begin
            @(negedge clk);
            c++;
        end
        check("busy_wait_timeout", 32'(c < 1000), 32'd1);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (c < 30000 && !(sb.size() == 0 && !in_frame && tx_busy === 1'b0 && empty === 1'b1)) begin
            @(negedge clk);
            c++;
        end
        check("idle_wait_timeout", 32'(c < 30000), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k, c, lows, done_before, ovf_before;
        rst_n = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(tx_busy), 32'd0);
        check("reset_done", 32'(tx_done), 32'd0);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full", 32'(full), 32'd0);
        check("reset_count", 32'(fifo_count), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        set_cfg(8, 1, 0);
        push_write(8'hA5);
        wait_idle();

        set_cfg(5, 2, 1);
        push_write(8'h1F);
        wait_idle();
        push_write(8'hFF);
        wait_idle();

        for (int b = 0; b < 8; b++) begin
            k = $urandom_range(1, 4);
            set_cfg($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1));
            for (int j = 0; j < k; j++) push_write(8'($urandom));
            if (k == 1) begin
                wait_busy();
                set_cfg($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1));
            end
            wait_idle();
        end

        // Keep the transmitter busy so the burst fills the FIFO without any pop.
        set_cfg(8, 0, 0);
        push_write(8'h5A);
        wait_busy();
        ovf_before = ovf_cnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < FD + 2; i++) begin
            wr_en = 1'b1;
            din   = 8'(i);
            if (i < FD) begin
                sb.push_back(model(8'(i), data_len, parity_mode, stop2));
                n_pushed++;
            end
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        @(negedge clk);
        #1;
        check("overflow_pulses", 32'(ovf_cnt - ovf_before), 32'd2);
        check("full_after_burst", 32'(full), 32'd1);
        check("count_after_burst", 32'(fifo_count), 32'(FD));
        wait_idle();
        check("count_after_drain", 32'(fifo_count), 32'd0);

        set_cfg(8, 0, 0);
        push_write(8'hFF);
        push_write(8'hFF);
        push_write(8'hFF);
        c = 0;
        while (c < 5000 && !(in_frame && mon_n >= 4 * OSR + OSR / 2)) begin
            @(negedge clk);
            c++;
        end
        check("reach_data_bit3", 32'(c < 5000), 32'd1);
        done_before = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_tx_high", 32'(tx), 32'd1);
        check("abort_busy", 32'(tx_busy), 32'd0);
        check("abort_empty", 32'(empty), 32'd1);
        check("abort_count", 32'(fifo_count), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        sb.delete();
        n_pushed -= 3;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("abort_line_idle", 32'(lows), 32'd0);
        check("abort_no_done", 32'(done_cnt - done_before), 32'd0);

`ifdef UART_TX_BREAK_EN
        begin
            exp_t eb;
            eb.bits = 32'd1 << (2 * (1 + DW + 2));
            eb.n    = 2 * (1 + DW + 2) + 1;
            set_cfg(8, 0, 0);
            @(posedge clk);
            #1;
            send_break = 1'b1;
            wr_en      = 1'b1;
            din        = 8'($urandom);
            sb.push_back(eb);
            sb.push_back(model(din, data_len, parity_mode, stop2));
            n_pushed += 2;
            @(posedge clk);
            #1;
            send_break = 1'b0;
            wr_en      = 1'b0;
            wait_idle();
        end
`endif

        check("total_done_pulses", 32'(done_cnt), 32'(n_pushed));
        check("final_count", 32'(fifo_count), 32'd0);
        check("final_tx", 32'(tx), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_multi.md
# uart_tx_multi

Parametrised UART transmitter with an internal transmit FIFO and per-frame runtime configuration of data length, parity mode and stop-bit count. It is the successor to the single-byte `uart_tx`. It is driven by the oversampling `tick` from `uart_baudgen`, queues bytes from the host side and emits back-to-back frames on `tx` without host intervention.

## Interface
- `DATA_WD`, 8: maximum data width and FIFO word width; legal range 5–9.
- `OVERSAMPLING_RATE`, 16: ticks per bit period.
- `FIFO_DEPTH`, 8: FIFO entries; must be a power of two, ≥2.
- `CNT_WD`, $clog2(FIFO_DEPTH)+1: width of `fifo_count`.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-`clk` pulse at BAUD×OVERSAMPLING_RATE, from `uart_baudgen`.
- `wr_en` in 1: push `din` into the FIFO.
- `din` in DATA_WD: data word to queue; LSB is transmitted first.
- `data_len` in 4: data bits per frame, 5..DATA_WD. Out-of-range values are clamped to DATA_WD.
- `parity_mode` in 2: 1 = odd, 2 = even, 0 or 3 = no parity.
- `stop2` in 1: 0 = one stop bit, 1 = two stop bits.
- `tx` out 1: serial line; idles high.
- `tx_busy` out 1: high whenever the state is not IDLE.
- `tx_done` out 1: one-`clk` pulse at the end of each frame.
- `full` out 1: FIFO full.
- `empty` out 1: FIFO empty.
- `fifo_count` out CNT_WD: number of occupied entries.
- `overflow` out 1: one-`clk` pulse when a write is dropped.

## Operation
- One-hot FSM with states IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE: when `!empty`, pop the FIFO head into the shift register. Latch `data_len`, `parity_mode` and `stop2` into frame registers. Clear `tick_count` and `bit_index`, then go to START. Config input changes mid-frame have no effect until the next pop.
- START: drive `tx` = 0.
- DATA: drive `tx` = shift register bit `bit_index`, over `bit_index` = 0..len−1.
- PARITY: entered only if the latched mode is 1 or 2. Odd mode sends ~^data[len−1:0]; even mode sends ^data[len−1:0]. Only the latched `len` bits are included.
- STOP: drive `tx` = 1 for 1 or 2 bit periods.
- DONE: one `clk` with `tx` = 1 and `tx_done` = 1, then go to IDLE.
- Each bit lasts exactly OVERSAMPLING_RATE ticks. `tick_count` increments on `tick`. At `tick_count` = OVERSAMPLING_RATE−1 with `tick` high, the bit ends and `tick_count` wraps to 0.
- FIFO write: accepted when `wr_en && !full`. A write while full is dropped and pulses `overflow`. `full` is evaluated on the registered state, so a write is dropped even if a pop occurs in the same cycle.
- Simultaneous write and pop with the FIFO not full: `fifo_count` is unchanged.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values, applied asynchronously and immediately:
  - `tx` = 1, `tx_busy` = 0, `tx_done` = 0, `overflow` = 0
  - `full` = 0, `empty` = 1, `fifo_count` = 0
  - state = IDLE
  - FIFO contents discarded
- Reset mid-frame aborts the frame and returns `tx` high in the same instant.
- `wr_en` at edge N updates `fifo_count` and `empty` at edge N+1.
- Pop into START occurs at edge N+1 if IDLE and not empty, so `tx` falls 1 `clk` after the write into an empty FIFO.
- Frame length is (1 + len + P + S)×OVERSAMPLING_RATE ticks plus 2 `clk` (DONE and IDLE), where P ∈ {0,1} and S ∈ {1,2}.
- Back-to-back frames: the next start bit begins 2 `clk` after the last stop bit ends.

## Configuration
- `UART_TX_BREAK_EN` defined: adds input port `send_break`.
  - Sampled in IDLE with priority over FIFO pop.
  - Holds `tx` = 0 for 2×(1+DATA_WD+2)×OVERSAMPLING_RATE ticks, with `tx_busy` = 1.
  - Then passes through STOP (1 bit) and DONE, with `tx_done` pulsing.
  - FIFO is untouched.
- Not defined: no `send_break` port, no break logic; behaviour is exactly as specified above.

## Test plan
- Reset: hold `rst_n` = 0 for 10 `clk` → `tx` = 1, `tx_busy` = 0, `empty` = 1, `fifo_count` = 0, state IDLE.
- Odd parity, 8 bits, 1 stop, `din` = 0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1,1; each bit 16 ticks; one `tx_done` pulse.
- Even parity, `data_len` = 5, `stop2` = 1, `din` = 0x1F → 0,1,1,1,1,1,1,1,1; parity 1; upper `din` bits ignored.
- Write FIFO_DEPTH+2 words 0x00..0x09 in consecutive cycles → `overflow` pulses twice. Then 8 back-to-back frames 0x00..0x07 (0x08 and 0x09 dropped), `tx_done` pulsing 8 times, `fifo_count` ending at 0.
- Assert `rst_n` low during the DATA bit 3 of a 0xFF frame with 3 words queued → `tx` = 1 immediately, FIFO empty, no `tx_done`.
- With `UART_TX_BREAK_EN` defined: `send_break` while 1 word is queued → break low period of the specified tick count first, then the queued frame transmits normally.
